// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with a single decode-facing register.
//
// Holds the program counter, drives the instruction memory with a word
// address, captures the returned word into a valid/ready handshake register
// for decode, and counts instructions accepted by decode. A branch redirect
// from execute overrides every other update in its cycle.
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   fetch_en       in   1 = fetching permitted
//   rom_ce         out  instruction-memory enable (high only while running)
//   rom_addr       out  word address into instruction memory (pc[ADDR_W+1:2])
//   rom_inst       in   instruction word, combinationally valid with rom_addr
//   branch_valid   in   single-cycle redirect request
//   branch_target  in   redirect byte address
//   id_valid       out  id_pc/id_inst hold an instruction for decode
//   id_ready       in   decode accepts the instruction this cycle
//   id_pc          out  byte address of id_inst
//   id_inst        out  fetched instruction
//   fetch_cnt      out  instructions accepted by decode since reset (wraps)
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    input  logic              branch_valid,
    input  logic [31:0]       branch_target,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_inst,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q,    pc_d;
    logic        valid_q, valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] inst_q,  inst_d;
    logic [31:0] cnt_q,   cnt_d;

    logic        acc;
    logic        ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            id_pc_q <= '0;
            inst_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            id_pc_q <= id_pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        acc = valid_q & id_ready;
        // A load also needs fetch_en: in the last RUN cycle before dropping
        // to IDLE the register may only drain, never refill.
        ld  = (state_q == S_RUN) & fetch_en & (~valid_q | id_ready) & ~branch_valid;

        state_d = fetch_en ? S_RUN : S_IDLE;
        pc_d    = pc_q;
        valid_d = valid_q;
        id_pc_d = id_pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q + 32'(acc);

        if (branch_valid) begin
            pc_d    = branch_target;
            valid_d = 1'b0;
            inst_d  = '0;
        end else if (ld) begin
            inst_d  = rom_inst;
            id_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
        end else if (acc) begin
            valid_d = 1'b0;
        end
    end

    assign rom_ce    = (state_q == S_RUN);
    assign rom_addr  = pc_q[ADDR_W+1:2];
    assign id_valid  = valid_q;
    assign id_pc     = id_pc_q;
    assign id_inst   = inst_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch.
// A behavioural fetch model is stepped on each clock edge and compared with
// the DUT on every falling edge; directed literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        rom_ce;
    logic [5:0]  rom_addr;
    logic [31:0] rom_inst;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [64];

    if_fetch #(
        .RESET_PC (32'h0),
        .ADDR_W   (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .fetch_cnt     (fetch_cnt)
    );

    // Instruction memory: returns 0 when disabled.
    assign rom_inst = rom_ce ? rom[rom_addr] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_run;
    logic [31:0] m_pc;
    logic        m_v;
    logic [31:0] m_idpc;
    logic [31:0] m_inst;
    logic [31:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  = 1'b0;
            m_pc   = 32'h0;
            m_v    = 1'b0;
            m_idpc = 32'h0;
            m_inst = 32'h0;
            m_cnt  = 32'h0;
        end else begin
            logic accepted;
            accepted = m_v && id_ready;
            if (accepted) m_cnt = m_cnt + 1;
            if (branch_valid) begin
                m_pc   = branch_target;
                m_v    = 1'b0;
                m_inst = 32'h0;
            end else if (m_run && fetch_en && (!m_v || id_ready)) begin
                m_inst = rom[m_pc[7:2]];
                m_idpc = m_pc;
                m_v    = 1'b1;
                m_pc   = m_pc + 32'd4;
            end else if (accepted) begin
                m_v = 1'b0;
            end
            m_run = fetch_en;
        end
    end

    always @(negedge clk) begin
        chk("model_rom_ce",    {31'b0, rom_ce},   {31'b0, m_run});
        chk("model_rom_addr",  {26'b0, rom_addr}, {26'b0, m_pc[7:2]});
        chk("model_id_valid",  {31'b0, id_valid}, {31'b0, m_v});
        chk("model_id_inst",   id_inst,           m_inst);
        chk("model_fetch_cnt", fetch_cnt,         m_cnt);
        if (m_v) chk("model_id_pc", id_pc, m_idpc);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] rdy_pat;
        rdy_pat = 16'b1011_0010_1110_0101;
        for (int i = 0; i < 64; i++) rom[i] = 32'h1000 + i;
        rom[0] = 32'h11;
        rom[1] = 32'h22;
        rom[2] = 32'h33;
        rom[3] = 32'h44;

        rst_n = 1'b0; fetch_en = 1'b0; id_ready = 1'b0;
        branch_valid = 1'b0; branch_target = 32'h0;
        step(); step();
        chk("rst_rom_ce",   {31'b0, rom_ce},   32'h0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_cnt",      fetch_cnt,         32'h0);
        chk("rst_id_inst",  id_inst,           32'h0);
        chk("rst_id_pc",    id_pc,             32'h0);
        chk("rst_rom_addr", {26'b0, rom_addr}, 32'h0);

        // Streaming
        rst_n = 1'b1; fetch_en = 1'b1; id_ready = 1'b1;
        step();
        chk("st_rom_ce",   {31'b0, rom_ce},   32'h1);
        chk("st_valid0",   {31'b0, id_valid}, 32'h0);
        step();
        chk("st_inst0", id_inst, 32'h11); chk("st_pc0", id_pc, 32'h0); chk("st_cnt0", fetch_cnt, 32'h0);
        step();
        chk("st_inst1", id_inst, 32'h22); chk("st_pc1", id_pc, 32'h4); chk("st_cnt1", fetch_cnt, 32'h1);

        // Stall three cycles on 0x22
        id_ready = 1'b0;
        step(); step(); step();
        chk("stall_inst", id_inst, 32'h22); chk("stall_pc", id_pc, 32'h4);
        chk("stall_addr", {26'b0, rom_addr}, 32'h2); chk("stall_cnt", fetch_cnt, 32'h1);
        id_ready = 1'b1;
        step();
        chk("st_inst2", id_inst, 32'h33); chk("st_pc2", id_pc, 32'h8); chk("st_cnt2", fetch_cnt, 32'h2);
        step();
        chk("st_inst3", id_inst, 32'h44); chk("st_pc3", id_pc, 32'hC); chk("st_cnt3", fetch_cnt, 32'h3);

        // Redirect to 0x20 while id_valid = 1
        branch_valid = 1'b1; branch_target = 32'h20;
        step();
        branch_valid = 1'b0;
        chk("br_valid", {31'b0, id_valid}, 32'h0); chk("br_inst", id_inst, 32'h0);
        chk("br_addr", {26'b0, rom_addr}, 32'h8); chk("br_cnt", fetch_cnt, 32'h4);
        step();
        chk("br_inst8", id_inst, 32'h1008); chk("br_pc8", id_pc, 32'h20); chk("br_cnt8", fetch_cnt, 32'h4);

        // Misaligned target
        branch_valid = 1'b1; branch_target = 32'h23;
        step();
        branch_valid = 1'b0;
        chk("mis_addr", {26'b0, rom_addr}, 32'h8); chk("mis_cnt", fetch_cnt, 32'h5);
        step();
        chk("mis_inst", id_inst, 32'h1008); chk("mis_pc", id_pc, 32'h23);

        // Wrap at word 63
        branch_valid = 1'b1; branch_target = 32'hFC;
        step();
        branch_valid = 1'b0;
        chk("wr_addr63", {26'b0, rom_addr}, 32'd63); chk("wr_cnt", fetch_cnt, 32'h6);
        step();
        chk("wr_inst63", id_inst, 32'h103F); chk("wr_pc63", id_pc, 32'hFC);
        chk("wr_addr0", {26'b0, rom_addr}, 32'h0);
        step();
        chk("wr_inst0", id_inst, 32'h11); chk("wr_pc100", id_pc, 32'h100); chk("wr_cnt7", fetch_cnt, 32'h7);

        // Enable drop while id_valid = 1 and id_ready = 1
        fetch_en = 1'b0;
        step();
        chk("ed_valid", {31'b0, id_valid}, 32'h0); chk("ed_rom_ce", {31'b0, rom_ce}, 32'h0);
        chk("ed_addr", {26'b0, rom_addr}, 32'h1); chk("ed_cnt", fetch_cnt, 32'h8);
        step();
        chk("ed_hold_addr", {26'b0, rom_addr}, 32'h1);
        fetch_en = 1'b1;
        step();
        chk("re_rom_ce", {31'b0, rom_ce}, 32'h1); chk("re_valid", {31'b0, id_valid}, 32'h0);
        step();
        chk("re_inst", id_inst, 32'h22); chk("re_pc", id_pc, 32'h104); chk("re_cnt", fetch_cnt, 32'h8);

        // Redirect while idle
        fetch_en = 1'b0;
        step();
        branch_valid = 1'b1; branch_target = 32'h40;
        step();
        branch_valid = 1'b0;
        chk("bi_rom_ce", {31'b0, rom_ce}, 32'h0); chk("bi_addr", {26'b0, rom_addr}, 32'd16);
        chk("bi_cnt", fetch_cnt, 32'h9);

        // Mixed ready pattern, checked by the model
        fetch_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            id_ready = rdy_pat[i];
            step();
        end

        // Async reset in the middle of a stall
        id_ready = 1'b0;
        step(); step();
        chk("pre_rst_valid", {31'b0, id_valid}, 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rom_ce",   {31'b0, rom_ce},   32'h0);
        chk("ar_valid",    {31'b0, id_valid}, 32'h0);
        chk("ar_inst",     id_inst,           32'h0);
        chk("ar_pc",       id_pc,             32'h0);
        chk("ar_addr",     {26'b0, rom_addr}, 32'h0);
        chk("ar_cnt",      fetch_cnt,         32'h0);
        step(); step();
        rst_n = 1'b1; id_ready = 1'b1;
        step();
        step();
        chk("post_inst", id_inst, 32'h11); chk("post_pc", id_pc, 32'h0); chk("post_cnt", fetch_cnt, 32'h0);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
